// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: fetch FSM state encoding and instruction size shared by the fetch queue
package instr_fetch_queue_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        WAIT_BSY = 2'd3
    } ifq_state_t;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: cache port-B request/response and decode-side instruction stream
interface instr_fetch_queue_if #(
    parameter int ADDRESS_BITWIDTH     = 10,
    parameter int INSTRUCTION_BITWIDTH = 32
);
    logic [ADDRESS_BITWIDTH-1:0]     c_addr;
    logic                            c_en;
    logic [INSTRUCTION_BITWIDTH-1:0] c_dout;
    logic                            c_rdy;
    logic                            c_bsy;
    logic [INSTRUCTION_BITWIDTH-1:0] ins;
    logic [ADDRESS_BITWIDTH-1:0]     ins_pc;
    logic                            ins_valid;
    logic                            ins_ready;
    modport master (
        output c_addr, c_en, ins, ins_pc, ins_valid,
        input  c_dout, c_rdy, c_bsy, ins_ready
    );
    modport slave (
        input  c_addr, c_en, ins, ins_pc, ins_valid,
        output c_dout, c_rdy, c_bsy, ins_ready
    );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// ifq_fifo: circular-pointer FIFO with explicit count, flush priority and empty-pop protection
module ifq_fifo #(
    parameter int WIDTH      = 42,
    parameter int DEPTH_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    din,
    input  logic                pop,
    input  logic                flush,
    output logic [WIDTH-1:0]    head,
    output logic [DEPTH_BITS:0] count,
    output logic                valid
);
    localparam int DEPTH = 2 ** DEPTH_BITS;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd, wr;
    logic                  do_pop, do_push;
    assign valid   = |count;
    assign head    = mem[rd];
    assign do_pop  = pop && valid;
    assign do_push = push && (!count[DEPTH_BITS] || do_pop);
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) mem[wr] <= din;
            wr    <= do_push ? wr + DEPTH_BITS'(1) : wr;
            rd    <= do_pop ? rd + DEPTH_BITS'(1) : rd;
            count <= count + (DEPTH_BITS+1)'(do_push) - (DEPTH_BITS+1)'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: cache port-B fetch FSM with PC tracking, redirect/discard and decode FIFO; IFQ_STATS_EN adds counters
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH     = 10,
    parameter int INSTRUCTION_BITWIDTH = 32,
    parameter int QUEUE_DEPTH_BITWIDTH = 2,
    parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect,
    input  logic [ADDRESS_BITWIDTH-1:0] redirect_pc,
    instr_fetch_queue_if.master         bus
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]                 stat_fetched,
    output logic [31:0]                 stat_stall
`endif
);
    localparam int AW = ADDRESS_BITWIDTH;
    localparam int IW = INSTRUCTION_BITWIDTH;
    localparam int QB = QUEUE_DEPTH_BITWIDTH;
    ifq_state_t      state;
    logic [AW-1:0]   fetch_pc;
    logic            discard;
    logic [QB:0]     count;
    logic [IW+AW-1:0] head;
    logic            rdy_now, push, pop, issue_ok;
    assign rdy_now  = state == WAIT_RDY && bus.c_rdy;
    assign push     = rdy_now && !discard && !redirect;
    assign pop      = bus.ins_valid && bus.ins_ready;
    assign issue_ok = state == IDLE && !bus.c_bsy && !count[QB] && !redirect;
    assign {bus.ins, bus.ins_pc} = head;
    ifq_fifo #(.WIDTH(IW + AW), .DEPTH_BITS(QB)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({bus.c_dout, bus.c_addr}),
        .pop   (pop),
        .flush (redirect),
        .head  (head),
        .count (count),
        .valid (bus.ins_valid)
    );
    // a redirect that lands together with c_rdy consumes that result itself, so no discard is armed
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
            bus.c_en   <= 1'b0;
            bus.c_addr <= RESET_PC;
        end else begin
            bus.c_en   <= issue_ok;
            bus.c_addr <= issue_ok ? fetch_pc : bus.c_addr;
            fetch_pc   <= redirect ? {redirect_pc[AW-1:2], 2'b00}
                        : push ? fetch_pc + AW'(INSTR_BYTES) : fetch_pc;
            discard    <= (redirect && (state == ISSUE || (state == WAIT_RDY && !bus.c_rdy))) ? 1'b1
                        : rdy_now ? 1'b0 : discard;
            state      <= state == IDLE  ? (issue_ok ? ISSUE : IDLE)
                        : state == ISSUE ? WAIT_RDY
                        : state == WAIT_RDY ? (!bus.c_rdy ? WAIT_RDY : bus.c_bsy ? WAIT_BSY : IDLE)
                        : (bus.c_bsy ? WAIT_BSY : IDLE);
        end
    end
`ifdef IFQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            stat_fetched <= stat_fetched + 32'(push);
            stat_stall   <= stat_stall + 32'(bus.ins_ready && !bus.ins_valid);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with a port-B cache responder model
module tb_instr_fetch_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       redirect = 1'b0;
    logic [9:0] redirect_pc = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         en_cnt = 0;
    logic [9:0] last_addr = '0;
    logic [31:0] rom [256];
    logic       pend = 1'b0;
    logic       tail = 1'b0;
    int         lat = 0;
    logic [9:0] req_addr = '0;
`ifdef IFQ_STATS_EN
    logic [31:0] stat_fetched, stat_stall;
`endif
    instr_fetch_queue_if #(.ADDRESS_BITWIDTH(10), .INSTRUCTION_BITWIDTH(32)) bus ();
    instr_fetch_queue #(
        .ADDRESS_BITWIDTH(10), .INSTRUCTION_BITWIDTH(32), .QUEUE_DEPTH_BITWIDTH(2), .RESET_PC(10'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
`ifdef IFQ_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_stall   (stat_stall)
`endif
    );
    always #5 clk = ~clk;
    // cache responder: acts on falling edges; rdy arrives 3 cycles after the request, busy lingers one cycle
    always @(negedge clk) begin
        bus.c_rdy = 1'b0;
        if (!rst) begin
            pend = 1'b0;
            tail = 1'b0;
            bus.c_bsy = 1'b0;
        end else if (pend) begin
            if (lat == 0) begin
                bus.c_rdy  = 1'b1;
                bus.c_dout = rom[req_addr[9:2]];
                pend = 1'b0;
                tail = 1'b1;
            end else lat--;
        end else if (tail) begin
            tail = 1'b0;
            bus.c_bsy = 1'b0;
        end else if (bus.c_en) begin
            pend = 1'b1;
            lat = 2;
            bus.c_bsy = 1'b1;
            req_addr = bus.c_addr;
        end
        if (bus.c_en === 1'b1) begin
            en_cnt++;
            last_addr = bus.c_addr;
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_en(input int bound);
        for (int i = 0; i < bound && bus.c_en !== 1'b1; i++) tick();
        chk("wait_c_en", 32'(bus.c_en), 32'd1);
    endtask
    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && bus.ins_valid !== 1'b1; i++) tick();
        chk("wait_ins_valid", 32'(bus.ins_valid), 32'd1);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_c_en"}, 32'(bus.c_en), 32'd0);
        chk({tag, "_c_addr"}, 32'(bus.c_addr), 32'h000);
        chk({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'd0);
        chk({tag, "_ins"}, bus.ins, 32'h0);
        chk({tag, "_ins_pc"}, 32'(bus.ins_pc), 32'h000);
    endtask
    initial begin
        logic [31:0] exp_pc [5];
        logic [31:0] exp_ins [5];
        int idx;
        exp_pc  = '{32'h004, 32'h008, 32'h00C, 32'h010, 32'h014};
        exp_ins = '{32'h3F5A2E14, 32'hAB4C3E6F, 32'hA5A5000C, 32'hA5A50010, 32'hA5A50014};
        for (int i = 0; i < 256; i++) rom[i] = 32'hA5A50000 | 32'(i * 4);
        rom[0] = 32'hB7C6A980;
        rom[1] = 32'h3F5A2E14;
        rom[2] = 32'hAB4C3E6F;
        bus.c_dout = '0;
        bus.c_rdy = 1'b0;
        bus.c_bsy = 1'b0;
        bus.ins_ready = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();
        chk("first_c_en", 32'(bus.c_en), 32'd1);
        chk("first_c_addr", 32'(bus.c_addr), 32'h000);
        tick();
        chk("c_en_pulse_low", 32'(bus.c_en), 32'd0);
        wait_valid(20);
        chk("first_ins", bus.ins, 32'hB7C6A980);
        chk("first_ins_pc", 32'(bus.ins_pc), 32'h000);
        repeat (40) tick();
        chk("fill_issues", 32'(en_cnt), 32'd4);
        chk("fill_c_en_idle", 32'(bus.c_en), 32'd0);
        chk("fill_head_pc", 32'(bus.ins_pc), 32'h000);
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        chk("after_pop_head_pc", 32'(bus.ins_pc), 32'h004);
        repeat (20) tick();
        chk("one_pop_one_issue", 32'(en_cnt), 32'd5);
        bus.ins_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 200 && idx < 5; i++) begin
            if (bus.ins_valid === 1'b1) begin
                chk($sformatf("stream_pc_%0d", idx), 32'(bus.ins_pc), exp_pc[idx]);
                chk($sformatf("stream_ins_%0d", idx), bus.ins, exp_ins[idx]);
                idx++;
            end
            tick();
        end
        chk("stream_count", 32'(idx), 32'd5);
        wait_en(60);
        tick();
        redirect = 1'b1;
        redirect_pc = 10'h009;
        bus.ins_ready = 1'b0;
        tick();
        redirect = 1'b0;
        chk("redir_flush_valid", 32'(bus.ins_valid), 32'd0);
        wait_valid(60);
        chk("redir_head_pc", 32'(bus.ins_pc), 32'h008);
        chk("redir_head_ins", bus.ins, 32'hAB4C3E6F);
        chk("redir_issue_addr", 32'(last_addr), 32'h008);
        redirect = 1'b1;
        redirect_pc = 10'h3FC;
        tick();
        redirect = 1'b0;
        chk("wrap_flush_valid", 32'(bus.ins_valid), 32'd0);
        wait_valid(60);
        chk("wrap_head_pc", 32'(bus.ins_pc), 32'h3FC);
        chk("wrap_head_ins", bus.ins, 32'hA5A503FC);
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        wait_valid(60);
        chk("wrapped_pc", 32'(bus.ins_pc), 32'h000);
        chk("wrapped_ins", bus.ins, 32'hB7C6A980);
        bus.ins_ready = 1'b1;
        wait_en(60);
        tick();
        rst = 1'b0;
        bus.ins_ready = 1'b0;
        tick();
        chk_reset("midfetch_reset");
        rst = 1'b1;
        tick();
        chk("restart_c_en", 32'(bus.c_en), 32'd1);
        chk("restart_c_addr", 32'(bus.c_addr), 32'h000);
        wait_valid(20);
        chk("restart_ins_pc", 32'(bus.ins_pc), 32'h000);
        chk("restart_ins", bus.ins, 32'hB7C6A980);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch front-end sitting directly upstream of the Cache instruction port (port B: addrB/enB/rdyB/bsyB/doutB).
- Holds the fetch PC and issues one cache read at a time using the port-B pulse/ready/busy handshake.
- Buffers returned instructions with their PCs in a small FIFO for the CPU decode stage.
- Supports pipeline redirect (branch/jump): flushes the FIFO and discards any in-flight result.

Parameters:
- ADDRESS_BITWIDTH, 10, byte-address width; matches Cache ADDRESS_BITWIDTH.
- INSTRUCTION_BITWIDTH, 32, instruction width.
- QUEUE_DEPTH_BITWIDTH, 2, FIFO depth = 2^QUEUE_DEPTH_BITWIDTH entries.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDRESS_BITWIDTH  new fetch byte address; bits [1:0] ignored, forced 0.
- c_addr  out  ADDRESS_BITWIDTH  to Cache addrB.
- c_en  out  1  to Cache enB; one-cycle request pulse.
- c_dout  in  INSTRUCTION_BITWIDTH  from Cache doutB.
- c_rdy  in  1  from Cache rdyB; c_dout valid this cycle.
- c_bsy  in  1  from Cache bsyB.
- ins  out  INSTRUCTION_BITWIDTH  FIFO head instruction.
- ins_pc  out  ADDRESS_BITWIDTH  FIFO head PC.
- ins_valid  out  1  FIFO non-empty.
- ins_ready  in  1  consumer pops head when ins_valid && ins_ready.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, fetch_pc=RESET_PC, FIFO empty, discard=0. Outputs: c_en=0, c_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0. Reset mid-fetch abandons the request; the Cache shares rst.
- FSM states IDLE, ISSUE, WAIT_RDY, WAIT_BSY. All outputs are registered.
- IDLE -> ISSUE when c_bsy=0, count < 2^QUEUE_DEPTH_BITWIDTH, and redirect=0. Otherwise stay in IDLE.
- ISSUE: c_en=1 for exactly one cycle, c_addr=fetch_pc. Next state is WAIT_RDY.
- WAIT_RDY: c_en=0.
  - On c_rdy=1: push {c_dout, c_addr} unless discard=1; fetch_pc += 4, unless discard or a redirect is being applied.
  - Then go to WAIT_BSY if c_bsy=1, else IDLE.
- WAIT_BSY: stay while c_bsy=1, then go to IDLE.
- Latency: first c_en is the 2nd cycle after rst rises. A push becomes visible on ins_valid the cycle after c_rdy.
- At most one outstanding request. Room is checked at issue, so a push never overflows.
- PC arithmetic: fetch_pc increments by 4 modulo 2^ADDRESS_BITWIDTH; wrap from max to 0 is silent.
- FIFO: circular pointers with an explicit count. Simultaneous push and pop: count unchanged, both occur. Pop while empty is ignored.
- Redirect (any state): FIFO flushed (count=0, ins_valid=0 next cycle), fetch_pc=redirect_pc & ~3.
  - If the state is ISSUE or WAIT_RDY, set discard=1; the returning result is dropped.
  - discard clears on the c_rdy that consumes it.
  - Redirect in the same cycle as c_rdy: that data is dropped.
  - Redirect in the same cycle as a pop: redirect wins.
  - Redirect in WAIT_BSY or IDLE: no discard; the next issue uses the new PC.
- c_addr holds its last value when c_en=0.

Optional Feature:
- Macro IFQ_STATS_EN.
- When defined, adds output stat_fetched (32 bits), counting instructions pushed into the FIFO.
- Also adds output stat_stall (32 bits), counting cycles with ins_ready=1 and ins_valid=0.
- Both counters reset to 0 and wrap.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=0, ISSUE=1, WAIT_RDY=2, WAIT_BSY=3) and the instruction-byte-size constant 4.
- One natural sub-module, ifq_fifo: parameterised width/depth FIFO with push, pop, flush, count, head outputs.
- The fetch FSM and PC logic stay in the top module.

Test Plan:
- Reset release with RAM.mem loaded -> c_en pulses with c_addr=0. After the miss, ins=0xB7C6A980, ins_pc=0, ins_valid=1.
- ins_ready=1 continuously -> stream ins_pc 0,4,8 with ins 0xB7C6A980, 0x3F5A2E14, 0xAB4C3E6F in order, no duplicates.
- ins_ready=0 -> exactly 4 entries fill, c_en stays 0. One pop -> exactly one new c_en.
- redirect=1, redirect_pc=0x009 during WAIT_RDY -> FIFO empties, in-flight data never appears. Next c_addr=0x008 and ins=0xAB4C3E6F.
- redirect to 0x3FC -> fetches 0x3FC then wraps to c_addr=0x000.
- rst low for one cycle during WAIT_RDY -> all outputs return to reset values and fetch restarts at RESET_PC.
